// File: rtl/uart_prog_loader_if.sv
// Program-memory write port of the UART program loader.
// The loader drives the master side; the memory (or a model) drives the slave side.
interface uart_prog_loader_if #(
  parameter int ADDR_W = 16
);
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              mem_we;
  logic              mem_ready;

  modport master (output mem_addr, output mem_wdata, output mem_we, input mem_ready);
  modport slave  (input mem_addr, input mem_wdata, input mem_we, output mem_ready);
endinterface

// File: rtl/uart_prog_loader.sv
// Load-frame parser and program-memory writer behind a UART byte receiver.
// Optional macro UART_LOADER_CHECKSUM_EN adds the trailing CSUM byte and its check.
module uart_prog_loader #(
  parameter int ADDR_W         = 16,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 3840
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [7:0]          rx_data,
  input  logic                rx_valid,
  uart_prog_loader_if.master  mem,
  output logic                busy,
  output logic                frame_done,
  output logic                frame_err,
  output logic [1:0]          err_code
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int ENT_W = ADDR_W + 8;

  typedef enum logic [2:0] {
    S_IDLE, S_AHI, S_ALO, S_LEN, S_DATA, S_CSUM, S_DRAIN
  } state_t;

  state_t              state_q, state_d;
  logic [7:0]          ahi_q, ahi_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [8:0]          rem_q, rem_d;
  logic [TMR_W-1:0]    tmr_q, tmr_d;
  logic [ENT_W-1:0]    fifo_q [FIFO_DEPTH];
  logic [ENT_W-1:0]    fifo_d [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]      cnt_q, cnt_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [7:0]          mem_wdata_q, mem_wdata_d;
  logic                mem_we_q, mem_we_d;
  logic                frame_done_q, frame_done_d;
  logic                frame_err_q, frame_err_d;
  logic [1:0]          err_code_q, err_code_d;
`ifdef UART_LOADER_CHECKSUM_EN
  logic [7:0]          sum_q, sum_d;
`endif
  logic                push, pop, timed;

  always_comb begin
    state_d      = state_q;
    ahi_d        = ahi_q;
    addr_d       = addr_q;
    rem_d        = rem_q;
    fifo_d       = fifo_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_we_d     = mem_we_q;
    frame_done_d = 1'b0;
    frame_err_d  = 1'b0;
    err_code_d   = err_code_q;
`ifdef UART_LOADER_CHECKSUM_EN
    sum_d        = sum_q;
`endif
    push  = 1'b0;
    pop   = (cnt_q != '0) && (!mem_we_q || mem.mem_ready);
    timed = state_q inside {S_AHI, S_ALO, S_LEN, S_DATA, S_CSUM};

    // Inter-byte timer: reloaded on every strobe, terminal count at zero.
    if (rx_valid)
      tmr_d = TMR_W'(TIMEOUT_CYCLES - 1);
    else if (tmr_q != '0)
      tmr_d = tmr_q - 1'b1;
    else
      tmr_d = tmr_q;

    case (state_q)
      S_IDLE:
        if (rx_valid && rx_data == 8'hA5) state_d = S_AHI;
      S_AHI:
        if (rx_valid) begin
          ahi_d   = rx_data;
          state_d = S_ALO;
`ifdef UART_LOADER_CHECKSUM_EN
          sum_d   = rx_data;
`endif
        end
      S_ALO:
        if (rx_valid) begin
          addr_d  = ADDR_W'({ahi_q, rx_data});
          state_d = S_LEN;
`ifdef UART_LOADER_CHECKSUM_EN
          sum_d   = sum_q + rx_data;
`endif
        end
      S_LEN:
        if (rx_valid) begin
          rem_d   = (rx_data == 8'h00) ? 9'd256 : {1'b0, rx_data};
          state_d = S_DATA;
`ifdef UART_LOADER_CHECKSUM_EN
          sum_d   = sum_q + rx_data;
`endif
        end
      S_DATA:
        if (rx_valid) begin
          if (cnt_q == (PTR_W+1)'(FIFO_DEPTH) && !pop) begin
            frame_err_d = 1'b1;
            err_code_d  = 2'b10;
            state_d     = S_IDLE;
          end else begin
            push   = 1'b1;
            addr_d = addr_q + 1'b1;
            rem_d  = rem_q - 9'd1;
`ifdef UART_LOADER_CHECKSUM_EN
            sum_d  = sum_q + rx_data;
            if (rem_q == 9'd1) state_d = S_CSUM;
`else
            if (rem_q == 9'd1) state_d = S_DRAIN;
`endif
          end
        end
`ifdef UART_LOADER_CHECKSUM_EN
      S_CSUM:
        if (rx_valid) begin
          if (8'(sum_q + rx_data) == 8'h00) begin
            state_d = S_DRAIN;
          end else begin
            frame_err_d = 1'b1;
            err_code_d  = 2'b01;
            state_d     = S_IDLE;
          end
        end
`endif
      S_DRAIN:
        if (cnt_q == '0 && !mem_we_q) begin
          frame_done_d = 1'b1;
          state_d      = S_IDLE;
        end
      default: state_d = S_IDLE;
    endcase

    if (timed && !rx_valid && tmr_q == '0) begin
      frame_err_d = 1'b1;
      err_code_d  = 2'b11;
      state_d     = S_IDLE;
    end

    if (push) begin
      fifo_d[wr_ptr_q] = {addr_q, rx_data};
      wr_ptr_d         = wr_ptr_q + 1'b1;
    end

    // Write stage: refill from the FIFO whenever the current write retires.
    if (pop) begin
      rd_ptr_d    = rd_ptr_q + 1'b1;
      mem_addr_d  = fifo_q[rd_ptr_q][ENT_W-1:8];
      mem_wdata_d = fifo_q[rd_ptr_q][7:0];
      mem_we_d    = 1'b1;
    end else if (mem_we_q && mem.mem_ready) begin
      mem_we_d    = 1'b0;
    end

    cnt_d = cnt_q + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      ahi_q        <= '0;
      addr_q       <= '0;
      rem_q        <= '0;
      tmr_q        <= '0;
      fifo_q       <= '{default: '0};
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_we_q     <= 1'b0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
      err_code_q   <= 2'b00;
`ifdef UART_LOADER_CHECKSUM_EN
      sum_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      ahi_q        <= ahi_d;
      addr_q       <= addr_d;
      rem_q        <= rem_d;
      tmr_q        <= tmr_d;
      fifo_q       <= fifo_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_we_q     <= mem_we_d;
      frame_done_q <= frame_done_d;
      frame_err_q  <= frame_err_d;
      err_code_q   <= err_code_d;
`ifdef UART_LOADER_CHECKSUM_EN
      sum_q        <= sum_d;
`endif
    end
  end

  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_wdata = mem_wdata_q;
  assign mem.mem_we    = mem_we_q;
  assign frame_done    = frame_done_q;
  assign frame_err     = frame_err_q;
  assign err_code      = err_code_q;
  assign busy          = (state_q != S_IDLE) || (cnt_q != '0) || mem_we_q;
endmodule

// File: doc/uart_prog_loader.md
# uart_prog_loader

Frame parser and memory writer directly downstream of the UART byte receiver. Consumes the receiver's one-cycle `rx_valid` byte strobes, which carry no backpressure. Decodes load frames (header, address, length, payload, optional checksum) and writes each payload byte into program memory through a ready/valid write port, with a small FIFO absorbing memory stalls. Reports per-frame completion or error to the host-side control logic.

## Interface
- `ADDR_W`, 16: memory address width, legal range 8..16. Address bits above `ADDR_W-1` in the frame are discarded.
- `FIFO_DEPTH`, 4: payload FIFO depth, power of 2, at least 2.
- `TIMEOUT_CYCLES`, 3840: inter-byte timeout in clk cycles (two byte times at 192 clk/bit).
- `clk` in 1: single clock, 1.8432 MHz nominal. All logic is on its rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `rx_data` in 8: received byte, valid only when `rx_valid` is high.
- `rx_valid` in 1: one-cycle byte strobe from the UART receiver.
- `mem_addr` out ADDR_W: write address.
- `mem_wdata` out 8: write data.
- `mem_we` out 1: write request. Held, together with address and data, until `mem_ready`.
- `mem_ready` in 1: memory accepts the write on any cycle where `mem_we && mem_ready`.
- `busy` out 1: parser not in IDLE, or FIFO not empty, or `mem_we` high.
- `frame_done` out 1: one-cycle pulse when a good frame is fully written.
- `frame_err` out 1: one-cycle pulse when a frame is aborted.
- `err_code` out 2: code of the last error, valid from the `frame_err` pulse until the next one. 01 = checksum, 10 = overflow, 11 = timeout.

## Operation
- Frame format: `0xA5`, ADDR_HI, ADDR_LO, LEN, LEN payload bytes, CSUM. LEN = 0 means 256 bytes.
- Parser states: IDLE → AHI → ALO → LEN → DATA → CSUM → DRAIN → IDLE.
  - IDLE silently discards every byte except `0xA5`.
- DATA: each byte is pushed into the FIFO together with its address. The address starts at {ADDR_HI, ADDR_LO} and increments per byte, wrapping modulo 2^ADDR_W. A 9-bit remaining-byte counter moves the parser to CSUM after the last payload byte.
- Checksum: 8-bit sum of ADDR_HI, ADDR_LO, LEN, the payload bytes and CSUM must equal 0x00.
  - Mismatch: `frame_err` pulses with code 01 and the parser goes to IDLE.
  - Payload writes are never rolled back. The host resends the frame.
- DRAIN: waits until the FIFO is empty and `mem_we` is low, then pulses `frame_done` and returns to IDLE. Bytes that arrive during DRAIN are dropped.
- Overflow: a DATA byte is dropped if the FIFO is full and no pop happens in the same cycle.
  - Result: `frame_err` with code 10; the parser goes to IDLE.
  - A push and a pop in the same cycle with the FIFO full is legal.
- Timeout: in AHI, ALO, LEN, DATA and CSUM, a counter is cleared on every `rx_valid`.
  - When it reaches TIMEOUT_CYCLES: `frame_err` with code 11; the parser goes to IDLE.
  - The timeout is inactive in IDLE and DRAIN.
- Bytes already queued in the FIFO always drain to memory after an error.
- Write stage: when `mem_we` is low, or a write is accepted this cycle, and the FIFO is non-empty, pop the FIFO and present the next address/data with `mem_we` high. Otherwise `mem_we` goes low after an accepted write.

## Timing
- Reset values: `mem_we`, `frame_done`, `frame_err` = 0; `mem_addr`, `mem_wdata` = 0; `err_code` = 00; `busy` = 0. FIFO empty, parser in IDLE, counters cleared.
- Reset mid-frame or mid-write: any pending write is abandoned at the reset edge.
- Latency: a payload `rx_valid` at edge E gives `mem_we` high after edge E+1 when the FIFO and write stage are idle.
- Throughput: one write per cycle while `mem_ready` is held high.
- `frame_done` pulses the cycle after the drain condition is met. `frame_err` pulses the cycle after the offending byte or the timeout expiry.
- `frame_done` and `frame_err` are never high in the same cycle.

## Configuration
- `UART_LOADER_CHECKSUM_EN` defined: frame includes CSUM and the CSUM state is used as above.
- Undefined: no CSUM byte; the parser goes DATA → DRAIN after the last payload byte. Error code 01 is never produced.

## Test plan
- Good frame: A5 01 00 02 11 22 CA, `mem_ready` held at 1 → writes 0x0100=0x11, 0x0101=0x22, then one `frame_done` pulse, `busy` low afterwards.
- Bad checksum: same frame with CSUM = 0xCB → both writes still occur, `frame_err` pulses with `err_code` = 01, no `frame_done`.
- Stall overflow: `mem_ready` = 0, LEN = 6, bytes arriving back to back (1920 clk apart) → the 6th byte (FIFO_DEPTH 4 + 1 in the write stage) raises `frame_err` code 10. Releasing `mem_ready` then yields exactly 5 writes.
- Timeout: A5 00 10 followed by silence → `frame_err` code 11 exactly TIMEOUT_CYCLES after the last strobe, parser in IDLE, no writes.
- Address wrap and LEN = 0: ADDR_W = 8, frame A5 00 FF 00 plus 256 bytes → writes start at 0xFF then wrap to 0x00…0xFE, followed by `frame_done`.
- Reset mid-frame: assert `rst_n` = 0 during DATA with `mem_we` high → outputs at reset values after the edge. A following good frame completes normally.
